// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared constants, types and leading-zero helper for the LED scanner
package led_pkg;

  localparam int NUM_DIGITS = 4;
  localparam logic [3:0] AN_OFF = 4'b1111;

  typedef logic [1:0] dig_t;

  // Digit k>=1 is suppressed when it and every higher digit are zero and its dp is not requested.
  function automatic logic [3:0] lz_mask(input logic [15:0] v, input logic [3:0] dpm, input logic en);
    logic [3:0] m;
    logic zero_above;
    m = '0;
    zero_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_above = zero_above & (v[k*4 +: 4] == 4'h0);
      m[k] = en & zero_above & ~dpm[k];
    end
    return m;
  endfunction

endpackage

// File: rtl/led_digit_scanner.sv
// rtl/led_digit_scanner.sv - 4-digit multiplexed seven-segment scanner with dead-time and frame-synchronous loads
module led_digit_scanner
  import led_pkg::*;
#(
  parameter int PRESCALE = 50000,
  parameter int BLANK    = 2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  input  logic        load,
  input  logic        lz_en,
  output logic [3:0]  nibble,
  output logic [3:0]  an_n,
  output logic        dp_n,
  output logic        frame
);

  localparam int PW = $clog2(PRESCALE);

  logic [PW-1:0] pcnt;
  dig_t          dig;
  logic [15:0]   shadow_val, disp_val;
  logic [3:0]    shadow_dp, disp_dp;
  logic          pend;
  logic          wrap_q;

  logic       slot_end, wrap, in_blank, an_on;
  logic [3:0] supp;

  assign slot_end = (pcnt == PW'(PRESCALE - 1));
  assign wrap     = slot_end && (dig == 2'd3);

  generate
    if (BLANK == 0) begin : g_noblank
      assign in_blank = 1'b0;
    end else begin : g_blank
      assign in_blank = (pcnt < PW'(BLANK));
    end
  endgenerate

  assign supp  = lz_mask(disp_val, disp_dp, lz_en);
  assign an_on = !in_blank && !supp[dig];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt       <= '0;
      dig        <= '0;
      shadow_val <= '0;
      shadow_dp  <= '0;
      disp_val   <= '0;
      disp_dp    <= '0;
      pend       <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      if (slot_end) begin
        pcnt <= '0;
        dig  <= dig + 2'd1;
      end else begin
        pcnt <= pcnt + 1'b1;
      end
      wrap_q <= wrap;
      if (wrap && pend) begin
        disp_val <= shadow_val;
        disp_dp  <= shadow_dp;
        pend     <= 1'b0;
      end
      // A load on the wrap cycle re-arms pend after the transfer above, so it lands next frame.
      if (load) begin
        shadow_val <= value;
        shadow_dp  <= dp;
        pend       <= 1'b1;
      end
    end
  end

  // Pins register the current scan state, so they trail the counters by one clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nibble <= '0;
      an_n   <= AN_OFF;
      dp_n   <= 1'b1;
      frame  <= 1'b0;
    end else begin
      nibble <= disp_val[{dig, 2'b00} +: 4];
      an_n   <= an_on ? ~(4'b0001 << dig) : AN_OFF;
      dp_n   <= an_on ? ~disp_dp[dig] : 1'b1;
      frame  <= wrap_q;
    end
  end

endmodule

// File: tb/tb_led_digit_scanner.sv
// tb/tb_led_digit_scanner.sv - randomized and directed bench for led_digit_scanner against a cycle-count model
module tb_led_digit_scanner;

  localparam int P = 4;
  localparam int B = 1;
  localparam int PERIOD = 4 * P;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic        load = 1'b0;
  logic        lz_en = 1'b0;
  logic [3:0]  nibble;
  logic [3:0]  an_n;
  logic        dp_n;
  logic        frame;

  led_digit_scanner #(.PRESCALE(P), .BLANK(B)) dut (
    .clk(clk), .reset(reset), .value(value), .dp(dp), .load(load), .lz_en(lz_en),
    .nibble(nibble), .an_n(an_n), .dp_n(dp_n), .frame(frame)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Model: the scan position is simply the number of clock edges since reset release.
  int          pos;
  logic [15:0] m_disp, m_shv;
  logic [3:0]  m_disp_dp, m_shdp;
  logic        m_pend;
  logic        cur_lz;

  task automatic model_reset();
    pos = 0; m_disp = '0; m_shv = '0; m_disp_dp = '0; m_shdp = '0; m_pend = 1'b0;
  endtask

  function automatic bit suppressed(int d, logic [15:0] v, logic [3:0] dm, logic lz);
    return lz && d >= 1 && !dm[d] && ((v >> (4 * d)) == 16'h0);
  endfunction

  task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] d, input logic lz);
    int pc, dg;
    bit on;
    logic [3:0] e_nib, e_an;
    logic e_dpn, e_frame;
    load = ld; value = v; dp = d; lz_en = lz;
    @(posedge clk);
    pc = pos % P;
    dg = (pos / P) % 4;
    on = (pc >= B) && !suppressed(dg, m_disp, m_disp_dp, lz);
    e_nib   = 4'((m_disp >> (4 * dg)) & 16'hF);
    e_an    = on ? ~(4'b0001 << dg) : 4'b1111;
    e_dpn   = on ? ~m_disp_dp[dg] : 1'b1;
    e_frame = (pos > 0) && (pos % PERIOD == 0);
    pos++;
    if (pos % PERIOD == 0 && m_pend) begin
      m_disp = m_shv; m_disp_dp = m_shdp; m_pend = 1'b0;
    end
    if (ld) begin
      m_shv = v; m_shdp = d; m_pend = 1'b1;
    end
    #1;
    check("nibble", {12'h0, nibble}, {12'h0, e_nib});
    check("an_n", {12'h0, an_n}, {12'h0, e_an});
    check("dp_n", {15'h0, dp_n}, {15'h0, e_dpn});
    check("frame", {15'h0, frame}, {15'h0, e_frame});
    load = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'($urandom), 4'($urandom), cur_lz);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    step(1'b1, v, d, cur_lz);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_nibble"}, {12'h0, nibble}, 16'h0);
    check({tag, "_an_n"}, {12'h0, an_n}, 16'h000F);
    check({tag, "_dp_n"}, {15'h0, dp_n}, 16'h1);
    check({tag, "_frame"}, {15'h0, frame}, 16'h0);
  endtask

  initial begin
    cur_lz = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    reset = 1'b0;

    // Release: anode off on the first cycle, digit 0 on at the second.
    idle(1);
    check("release_c1_an", {12'h0, an_n}, 16'h000F);
    idle(1);
    check("release_c2_an", {12'h0, an_n}, 16'h000E);

    // Scan order with 1234.
    do_load(16'h1234, 4'h0);
    idle(2 * PERIOD + 3);

    // Two loads inside one frame: the later one wins.
    while ((pos % PERIOD) != P + 1) idle(1);
    do_load(16'hABCD, 4'h3);
    idle(1);
    do_load(16'h5678, 4'h5);
    idle(2 * PERIOD);

    // Leading-zero blanking.
    cur_lz = 1'b1;
    do_load(16'h0050, 4'h0);
    idle(2 * PERIOD + 2);
    do_load(16'h0000, 4'h0);
    idle(2 * PERIOD + 2);
    do_load(16'h0000, 4'b0100);
    idle(2 * PERIOD + 2);
    cur_lz = 1'b0;

    // Load coincident with the wrap edge is held over one frame.
    while (((pos + 1) % PERIOD) != 0) idle(1);
    do_load(16'h9E0F, 4'hA);
    idle(3 * PERIOD);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) cur_lz = ~cur_lz;
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 0) do_load(16'($urandom_range(0, 255)), 4'($urandom));
        else do_load(16'($urandom), 4'($urandom));
      end else idle(1);
    end

    // Asynchronous reset mid-slot with a pending load that must be discarded.
    do_load(16'hC3C3, 4'hF);
    while ((pos % P) != 2) idle(1);
    #3;
    reset = 1'b1;
    #1;
    check_reset_outputs("async");
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    idle(2 * PERIOD + 4);
    check("post_reset_pend", {15'h0, m_pend}, 16'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
